// File: rtl/frac_tcam_pe.sv
// frac_tcam_pe
// Fractured TCAM with DEPTH entries searched by a KEY_W-bit key.
// The key is cut into KEY_W/5 five-bit slices. Each slice owns a 32-row x DEPTH-bit
// table addressed by its 5-bit key field. An entry hits when its bit is set in the
// addressed row of every slice. Rules (value/mask) are expanded into all 32 rows of
// every slice by a row sweep. The lookup path is a three-stage pipeline that ends in
// a lowest-index priority encoder.
//
// Ports
//   clk, reset              clock, synchronous active-high reset
//   lkp_valid/lkp_ready     lookup handshake, lkp_key is the search key
//   res_valid               one-cycle result strobe, three cycles after the request cycle
//   res_hit/res_idx/res_vec any-hit flag, lowest hitting entry, full hit vector
//   wr_valid/wr_ready       rule write handshake
//   wr_idx/wr_key/wr_mask   entry, rule value, don't-care mask (1 = don't care)
//   wr_install              1 installs the rule, 0 invalidates the entry
//   wr_done                 pulse during the last row write of an update
module frac_tcam_pe #(
  parameter int KEY_W = 160,
  parameter int DEPTH = 64,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             lkp_valid,
  output logic             lkp_ready,
  input  logic [KEY_W-1:0] lkp_key,
  output logic             res_valid,
  output logic             res_hit,
  output logic [IDX_W-1:0] res_idx,
  output logic [DEPTH-1:0] res_vec,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [KEY_W-1:0] wr_key,
  input  logic [KEY_W-1:0] wr_mask,
  input  logic             wr_install,
  output logic             wr_done
);

  localparam int NS = KEY_W / 5;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_IDLE,
    ST_UPD
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [4:0]       row_q;
  logic [4:0]       row_d;

  logic [IDX_W-1:0] upd_idx_q;
  logic [KEY_W-1:0] upd_key_q;
  logic [KEY_W-1:0] upd_mask_q;
  logic             upd_install_q;

  logic [DEPTH-1:0] mem [NS][32];
  logic [NS-1:0]    upd_bit;

  logic             lkp_fire;
  logic             wr_fire;

  logic [DEPTH-1:0] s1_rows [NS];
  logic             s1_valid;
  logic [DEPTH-1:0] and_vec;
  logic [DEPTH-1:0] s2_vec;
  logic             s2_valid;
  logic [IDX_W-1:0] enc_idx;

  assign lkp_fire = lkp_valid & lkp_ready;
  assign wr_fire  = wr_valid & wr_ready;

  // Next-state and handshake logic for the controller.
  // INIT sweeps all 32 rows to clear the tables, IDLE serves lookups and accepts
  // writes (a pending write blocks lookups so it cannot be starved), and UPD sweeps
  // all 32 rows again to rewrite one entry's column. The row counter simply wraps
  // from 31 back to 0, which is exactly the value the next sweep needs.
  // wr_done is masked by reset so that an aborted update never signals completion.
  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    lkp_ready = 1'b0;
    wr_ready  = 1'b0;
    wr_done   = 1'b0;
    case (state_q)
      ST_INIT: begin
        row_d = row_q + 5'd1;
        if (row_q == 5'd31) begin
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        wr_ready  = 1'b1;
        lkp_ready = ~wr_valid;
        if (wr_valid) begin
          state_d = ST_UPD;
          row_d   = 5'd0;
        end
      end
      ST_UPD: begin
        row_d = row_q + 5'd1;
        if (row_q == 5'd31) begin
          wr_done = ~reset;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_INIT;
        row_d   = 5'd0;
      end
    endcase
  end

  // Controller state register. Reset always restarts the clearing sweep from row 0,
  // which also abandons any update that was in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_INIT;
      row_q   <= 5'd0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
    end
  end

  // Capture the rule being written when a write is accepted, so the upstream
  // request can change while the 32-row sweep is still running.
  always_ff @(posedge clk) begin
    if (reset) begin
      upd_idx_q     <= '0;
      upd_key_q     <= '0;
      upd_mask_q    <= '0;
      upd_install_q <= 1'b0;
    end else if (wr_fire) begin
      upd_idx_q     <= wr_idx;
      upd_key_q     <= wr_key;
      upd_mask_q    <= wr_mask;
      upd_install_q <= wr_install;
    end
  end

  // For the row being swept, decide per slice whether the entry should match.
  // A row value matches the rule slice when every non-masked bit agrees with it.
  // An invalidate simply writes zero into every row, so the entry can never hit.
  always_comb begin
    upd_bit = '0;
    for (int s = 0; s < NS; s++) begin
      upd_bit[s] = upd_install_q &
                   (((row_q ^ upd_key_q[5*s +: 5]) & ~upd_mask_q[5*s +: 5]) == 5'd0);
    end
  end

  // Table write port. INIT clears the whole row in every slice; UPD touches only
  // the column of the entry being written so all other rules stay untouched.
  // Writes are suppressed while reset is high so an aborted row is not written.
  // The tables themselves carry no reset; the INIT sweep is what clears them.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state_q == ST_INIT) begin
        for (int s = 0; s < NS; s++) begin
          mem[s][row_q] <= '0;
        end
      end else if (state_q == ST_UPD) begin
        for (int s = 0; s < NS; s++) begin
          mem[s][row_q][upd_idx_q] <= upd_bit[s];
        end
      end
    end
  end

  // Lookup stage 1: read the addressed row of every slice at the accept edge.
  // Lookups are never accepted during a sweep, so reads and writes never collide
  // and a lookup accepted before a write sees the old table contents.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= lkp_fire;
    end
    if (lkp_fire) begin
      for (int s = 0; s < NS; s++) begin
        s1_rows[s] <= mem[s][lkp_key[5*s +: 5]];
      end
    end
  end

  // An entry matches only when all slices agree, so fold the slice rows with AND.
  always_comb begin
    and_vec = '1;
    for (int s = 0; s < NS; s++) begin
      and_vec = and_vec & s1_rows[s];
    end
  end

  // Lookup stage 2: register the combined hit vector.
  always_ff @(posedge clk) begin
    if (reset) begin
      s2_valid <= 1'b0;
      s2_vec   <= '0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_vec <= and_vec;
      end
    end
  end

  // Priority encoder: scanning from the top down lets the lowest set bit win.
  // With no bit set the index stays zero.
  always_comb begin
    enc_idx = '0;
    for (int e = DEPTH - 1; e >= 0; e--) begin
      if (s2_vec[e]) begin
        enc_idx = IDX_W'(e);
      end
    end
  end

  // Lookup stage 3: present the result. There is no result backpressure, so the
  // strobe simply follows the pipeline valid and back-to-back lookups give one
  // result per cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      res_valid <= 1'b0;
      res_hit   <= 1'b0;
      res_idx   <= '0;
      res_vec   <= '0;
    end else begin
      res_valid <= s2_valid;
      if (s2_valid) begin
        res_vec <= s2_vec;
        res_hit <= |s2_vec;
        res_idx <= enc_idx;
      end
    end
  end

endmodule

// File: tb/tb_frac_tcam_pe.sv
// tb_frac_tcam_pe
// Self-checking bench for frac_tcam_pe with KEY_W=10, DEPTH=8.
// The reference model keeps each entry as a plain (valid, value, mask) rule and
// decides hits with a direct ternary compare. Expected results are queued at
// lookup acceptance and checked by a monitor when res_valid appears.
module tb_frac_tcam_pe;

  localparam int KEY_W = 10;
  localparam int DEPTH = 8;
  localparam int IDX_W = 3;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             lkp_valid = 1'b0;
  logic             lkp_ready;
  logic [KEY_W-1:0] lkp_key = '0;
  logic             res_valid;
  logic             res_hit;
  logic [IDX_W-1:0] res_idx;
  logic [DEPTH-1:0] res_vec;
  logic             wr_valid = 1'b0;
  logic             wr_ready;
  logic [IDX_W-1:0] wr_idx = '0;
  logic [KEY_W-1:0] wr_key = '0;
  logic [KEY_W-1:0] wr_mask = '0;
  logic             wr_install = 1'b0;
  logic             wr_done;

  typedef struct {
    logic [DEPTH-1:0] vec;
    logic             hit;
    logic [IDX_W-1:0] idx;
    int               due;
  } exp_t;

  exp_t             exp_q[$];
  exp_t             got;
  bit               rule_valid [DEPTH];
  logic [KEY_W-1:0] rule_key   [DEPTH];
  logic [KEY_W-1:0] rule_mask  [DEPTH];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int done_count = 0;

  frac_tcam_pe #(.KEY_W(KEY_W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .lkp_valid  (lkp_valid),
    .lkp_ready  (lkp_ready),
    .lkp_key    (lkp_key),
    .res_valid  (res_valid),
    .res_hit    (res_hit),
    .res_idx    (res_idx),
    .res_vec    (res_vec),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_idx     (wr_idx),
    .wr_key     (wr_key),
    .wr_mask    (wr_mask),
    .wr_install (wr_install),
    .wr_done    (wr_done)
  );

  always #5 clk = ~clk;

  // Safety net so the run always ends even if the design locks up.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected to finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference lookup: an entry hits when it is valid and the key agrees with the
  // rule value on every bit that is not masked. The lowest hitting entry wins.
  function automatic exp_t model_lookup(input logic [KEY_W-1:0] k, input int due);
    exp_t r;
    bit   found;
    r.vec = '0;
    r.idx = '0;
    r.due = due;
    found = 1'b0;
    for (int e = 0; e < DEPTH; e++) begin
      if (rule_valid[e] && (((k ^ rule_key[e]) & ~rule_mask[e]) == '0)) begin
        r.vec[e] = 1'b1;
        if (!found) begin
          r.idx = IDX_W'(e);
          found = 1'b1;
        end
      end
    end
    r.hit = found;
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compares presented results against the queue, counts wr_done pulses,
  // and records accepted requests into the model. Reset empties the model and drops
  // every pending expectation, since in-flight lookups must vanish.
  always @(negedge clk) begin
    cyc++;
    if (res_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_result: got res_valid=1 vec=%0h, expected no result pending", res_vec);
      end else begin
        got = exp_q.pop_front();
        checkOutput("res_vec", 32'(res_vec), 32'(got.vec));
        checkOutput("res_hit", 32'(res_hit), 32'(got.hit));
        checkOutput("res_idx", 32'(res_idx), 32'(got.idx));
        checkOutput("res_latency_cycle", cyc, got.due);
      end
    end
    if (wr_done) begin
      done_count++;
    end
    if (reset) begin
      exp_q.delete();
      for (int e = 0; e < DEPTH; e++) begin
        rule_valid[e] = 1'b0;
        rule_key[e]   = '0;
        rule_mask[e]  = '0;
      end
    end else begin
      if (lkp_valid && lkp_ready) begin
        exp_q.push_back(model_lookup(lkp_key, cyc + 3));
      end
      if (wr_valid && wr_ready) begin
        rule_valid[wr_idx] = wr_install;
        rule_key[wr_idx]   = wr_key;
        rule_mask[wr_idx]  = wr_mask;
      end
    end
  end

  // Issue one lookup or write request and hold it until it is accepted.
  task automatic applyStimulus(input bit is_wr, input logic [KEY_W-1:0] key,
                               input logic [KEY_W-1:0] mask, input logic [IDX_W-1:0] idx,
                               input bit inst);
    bit acc;
    acc = 1'b0;
    @(posedge clk);
    #1;
    if (is_wr) begin
      wr_valid   = 1'b1;
      wr_key     = key;
      wr_mask    = mask;
      wr_idx     = idx;
      wr_install = inst;
    end else begin
      lkp_valid = 1'b1;
      lkp_key   = key;
    end
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk);
      if (is_wr ? wr_ready : lkp_ready) acc = 1'b1;
    end
    @(posedge clk);
    #1;
    wr_valid  = 1'b0;
    lkp_valid = 1'b0;
    if (!acc) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: got no ready within 200 cycles, expected acceptance");
    end
  endtask

  // Called right after a write is accepted: both handshakes must stay low for the
  // 32-row sweep and wr_done must have pulsed the expected number of times.
  task automatic wait_update_end(input int d0, input int exp_pulses);
    int cnt;
    bit fin;
    cnt = 0;
    fin = 1'b0;
    for (int i = 0; i < 100 && !fin; i++) begin
      @(negedge clk);
      if (lkp_ready && wr_ready) fin = 1'b1;
      else cnt++;
    end
    checkOutput("upd_busy_cycles", cnt, 32);
    checkOutput("wr_done_pulses", done_count - d0, exp_pulses);
  endtask

  task automatic do_write(input logic [IDX_W-1:0] idx, input logic [KEY_W-1:0] key,
                          input logic [KEY_W-1:0] mask, input bit inst);
    int d0;
    d0 = done_count;
    applyStimulus(1'b1, key, mask, idx, inst);
    wait_update_end(d0, 1);
  endtask

  task automatic do_lookup(input logic [KEY_W-1:0] key);
    applyStimulus(1'b0, key, '0, '0, 1'b0);
  endtask

  // Pulse reset for one edge, then check reset values and the 32-cycle clear sweep.
  task automatic pulse_reset();
    int cnt;
    bit fin;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("rst_res_valid", 32'(res_valid), 0);
    checkOutput("rst_res_hit", 32'(res_hit), 0);
    checkOutput("rst_res_idx", 32'(res_idx), 0);
    checkOutput("rst_res_vec", 32'(res_vec), 0);
    checkOutput("rst_wr_done", 32'(wr_done), 0);
    checkOutput("rst_wr_ready", 32'(wr_ready), 0);
    cnt = 0;
    fin = 1'b0;
    for (int i = 0; i < 100 && !fin; i++) begin
      if (lkp_ready) fin = 1'b1;
      else begin
        cnt++;
        @(negedge clk);
      end
    end
    checkOutput("init_busy_cycles", cnt, 32);
  endtask

  task automatic drain();
    repeat (6) @(negedge clk);
    checkOutput("scoreboard_drained", exp_q.size(), 0);
  endtask

  initial begin
    int d0;
    bit acc;
    logic [KEY_W-1:0] k;
    int i_sel;

    for (int e = 0; e < DEPTH; e++) begin
      rule_valid[e] = 1'b0;
      rule_key[e]   = '0;
      rule_mask[e]  = '0;
    end

    $display("[TB] reset and clear sweep");
    pulse_reset();

    $display("[TB] lookups into an empty table");
    do_lookup(10'h155);
    do_lookup(10'h000);
    do_lookup(KEY_W'($urandom));

    $display("[TB] exact rule install");
    do_write(3'd5, 10'h155, 10'h000, 1'b1);
    do_lookup(10'h155);
    do_lookup(10'h154);

    $display("[TB] full wildcard and duplicate rules");
    do_write(3'd5, 10'h155, 10'h000, 1'b0);
    do_write(3'd2, 10'h000, 10'h3FF, 1'b1);
    do_write(3'd6, 10'h155, 10'h000, 1'b1);
    do_lookup(10'h155);
    do_lookup(10'h2AA);

    $display("[TB] invalidate");
    do_write(3'd2, 10'h000, 10'h000, 1'b0);
    do_lookup(10'h155);
    do_lookup(10'h000);
    drain();

    $display("[TB] back-to-back lookups followed by a write");
    @(posedge clk);
    #1;
    lkp_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      lkp_key = (i == 0) ? 10'h155 : (i == 1) ? 10'h2A5 : 10'h2AB;
      @(posedge clk);
      #1;
    end
    lkp_valid  = 1'b0;
    wr_valid   = 1'b1;
    wr_idx     = 3'd3;
    wr_key     = 10'h2AB;
    wr_mask    = 10'h00F;
    wr_install = 1'b1;
    d0 = done_count;
    acc = 1'b0;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      if (wr_ready) acc = 1'b1;
    end
    @(posedge clk);
    #1;
    wr_valid = 1'b0;
    checkOutput("b2b_write_accepted", 32'(acc), 1);
    wait_update_end(d0, 1);
    do_lookup(10'h2A0);
    drain();

    $display("[TB] random burst of lookups");
    @(posedge clk);
    #1;
    lkp_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      lkp_key = (i % 2 == 0) ? KEY_W'($urandom) : 10'h2A0 | KEY_W'($urandom_range(0, 15));
      @(posedge clk);
      #1;
    end
    lkp_valid = 1'b0;
    drain();

    $display("[TB] random mix of writes and lookups");
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        do_write(IDX_W'($urandom), KEY_W'($urandom),
                 KEY_W'($urandom) & KEY_W'($urandom) & KEY_W'($urandom),
                 $urandom_range(0, 3) != 0);
      end else begin
        i_sel = $urandom_range(0, DEPTH - 1);
        if ($urandom_range(0, 1) == 1 && rule_valid[i_sel]) begin
          k = rule_key[i_sel] ^ (rule_mask[i_sel] & KEY_W'($urandom));
        end else begin
          k = KEY_W'($urandom);
        end
        do_lookup(k);
      end
    end
    drain();

    $display("[TB] reset in the middle of an update");
    do_write(3'd0, 10'h3C3, 10'h000, 1'b1);
    do_write(3'd7, 10'h000, 10'h3FF, 1'b1);
    d0 = done_count;
    applyStimulus(1'b1, 10'h0F0, 10'h000, 3'd4, 1'b1);
    repeat (10) @(posedge clk);
    #1;
    pulse_reset();
    checkOutput("aborted_wr_done", done_count - d0, 0);
    do_lookup(10'h3C3);
    do_lookup(10'h0F0);
    do_lookup(10'h155);
    do_lookup(10'h2A0);
    do_lookup(KEY_W'($urandom));
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    checkOutput("post_reset_miss_vec", 32'(res_vec), 0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
